riscv_multi_cycle_control: RTL

//  Control FSM for the multi-cycle RV32I core, successor to the single-cycle datapath control.

---
 rtl/riscv_mc_pkg.sv | 21 ++
 rtl/riscv_mc_if.sv | 20 ++
 rtl/riscv_mc_decode.sv | 18 +
 rtl/riscv_multi_cycle_control.sv | 120 ++++++++++++
 4 files changed

// File: rtl/riscv_mc_pkg.sv
// riscv_mc_pkg: state, instruction-class and datapath-select encodings for the multi-cycle RV32I control
package riscv_mc_pkg;
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_ERROR} state_t;
    typedef enum logic [3:0] {C_R, C_I, C_LUI, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_ILL} iclass_t;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [1:0] PC_ALU = 2'b00, PC_ALUOUT = 2'b01, PC_JALR = 2'b10;
    localparam logic [1:0] A_PC = 2'b00, A_OLDPC = 2'b01, A_RS1 = 2'b10, A_ZERO = 2'b11;
    localparam logic [1:0] B_RS2 = 2'b00, B_FOUR = 2'b01, B_IMM = 2'b10;
    localparam logic [1:0] WB_ALUOUT = 2'b00, WB_MEM = 2'b01, WB_PC = 2'b10;
    localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_R = 3'd2, ALU_I = 3'd3, ALU_LUI = 3'd4;
    localparam logic [1:0] ERR_NONE = 2'b00, ERR_TIMEOUT = 2'b01, ERR_ILLEGAL = 2'b10;
endpackage

// File: rtl/riscv_mc_if.sv
// riscv_mc_if: signal bundle between the control FSM and the datapath/unified memory
interface riscv_mc_if #(parameter int INSTRET_W = 32);
    logic [6:0] op_i;
    logic [2:0] funct3_i;
    logic zero_i, mem_ready_i;
    logic mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o, reg_write_o, instr_done_o, err_o;
    logic [1:0] pc_src_o, alu_src_a_o, alu_src_b_o, wb_sel_o, err_code_o;
    logic [2:0] alu_op_o;
    logic [INSTRET_W-1:0] instret_o;
    modport master (
        input op_i, funct3_i, zero_i, mem_ready_i,
        output mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o, pc_src_o, alu_src_a_o,
        alu_src_b_o, alu_op_o, reg_write_o, wb_sel_o, instr_done_o, instret_o, err_o, err_code_o
    );
    modport slave (
        output op_i, funct3_i, zero_i, mem_ready_i,
        input mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o, pc_src_o, alu_src_a_o,
        alu_src_b_o, alu_op_o, reg_write_o, wb_sel_o, instr_done_o, instret_o, err_o, err_code_o
    );
endinterface

// File: rtl/riscv_mc_decode.sv
// riscv_mc_decode: maps the opcode field to an instruction class and a legal flag
module riscv_mc_decode
    import riscv_mc_pkg::*;
(
    input  logic [6:0] op,
    output iclass_t    cls,
    output logic       legal
);
    assign cls = (op == OP_R)      ? C_R      :
                 (op == OP_I)      ? C_I      :
                 (op == OP_LUI)    ? C_LUI    :
                 (op == OP_LOAD)   ? C_LOAD   :
                 (op == OP_STORE)  ? C_STORE  :
                 (op == OP_BRANCH) ? C_BRANCH :
                 (op == OP_JAL)    ? C_JAL    :
                 (op == OP_JALR)   ? C_JALR   : C_ILL;
    assign legal = (cls != C_ILL);
endmodule

// File: rtl/riscv_multi_cycle_control.sv
// riscv_multi_cycle_control: multi-cycle RV32I control FSM, memory watchdog, retire counter; ILLEGAL_TRAP_EN traps unknown opcodes
module riscv_multi_cycle_control
    import riscv_mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int INSTRET_W   = 32
) (
    input logic        clk,
    input logic        reset,
    riscv_mc_if.master bus
);
    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    state_t st, nxt;
    iclass_t cls;
    logic legal, in_req, timeout, taken;
    logic req, we, irw, pcw, rw, done;
    logic [CW-1:0] wait_cnt;
    logic [INSTRET_W-1:0] instret;
    logic [1:0] err_code, err_nxt;

    riscv_mc_decode u_dec (.op(bus.op_i), .cls(cls), .legal(legal));

    assign in_req  = (st == S_FETCH) || (st == S_MEM);
    assign timeout = (MEM_TIMEOUT > 0) && in_req && !bus.mem_ready_i &&
                     (32'(wait_cnt) + 32'd1 == 32'(MEM_TIMEOUT));
    assign taken   = ((bus.funct3_i == F3_BEQ) && bus.zero_i) || ((bus.funct3_i == F3_BNE) && !bus.zero_i);

    // next state and Moore outputs, with handshake strobes qualified by mem_ready_i
    always_comb begin
        nxt = st;
        err_nxt = err_code;
        req = 1'b0;
        we = 1'b0;
        irw = 1'b0;
        pcw = 1'b0;
        rw = 1'b0;
        done = 1'b0;
        bus.iord_o = 1'b0;
        bus.pc_src_o = PC_ALU;
        bus.alu_src_a_o = A_PC;
        bus.alu_src_b_o = B_FOUR;
        bus.alu_op_o = ALU_ADD;
        bus.wb_sel_o = WB_ALUOUT;
        case (st)
            S_FETCH: begin
                req = 1'b1;
                irw = bus.mem_ready_i;
                pcw = bus.mem_ready_i;
                nxt = bus.mem_ready_i ? S_DECODE : (timeout ? S_ERROR : S_FETCH);
                err_nxt = timeout ? ERR_TIMEOUT : err_code;
            end
            S_DECODE: begin
                bus.alu_src_a_o = A_OLDPC;
                bus.alu_src_b_o = B_IMM;
`ifdef ILLEGAL_TRAP_EN
                nxt = legal ? S_EXECUTE : S_ERROR;
                err_nxt = legal ? err_code : ERR_ILLEGAL;
`else
                done = !legal;
                nxt = legal ? S_EXECUTE : S_FETCH;
`endif
            end
            S_EXECUTE: begin
                bus.alu_src_a_o = (cls == C_LUI) ? A_ZERO : A_RS1;
                bus.alu_src_b_o = (cls == C_R || cls == C_BRANCH) ? B_RS2 : B_IMM;
                bus.alu_op_o = (cls == C_R) ? ALU_R : (cls == C_I) ? ALU_I : (cls == C_LUI) ? ALU_LUI :
                               (cls == C_BRANCH) ? ALU_SUB : ALU_ADD;
                bus.pc_src_o = PC_ALUOUT;
                bus.wb_sel_o = (cls == C_JAL) ? WB_PC : WB_ALUOUT;
                pcw = ((cls == C_BRANCH) && taken) || (cls == C_JAL);
                rw = (cls == C_JAL);
                done = (cls == C_BRANCH) || (cls == C_JAL);
                nxt = done ? S_FETCH : (cls == C_LOAD || cls == C_STORE) ? S_MEM : S_WRITEBACK;
            end
            S_MEM: begin
                req = 1'b1;
                we = (cls == C_STORE);
                bus.iord_o = 1'b1;
                done = bus.mem_ready_i && (cls == C_STORE);
                nxt = bus.mem_ready_i ? ((cls == C_STORE) ? S_FETCH : S_WRITEBACK) : (timeout ? S_ERROR : S_MEM);
                err_nxt = timeout ? ERR_TIMEOUT : err_code;
            end
            S_WRITEBACK: begin
                rw = 1'b1;
                done = 1'b1;
                pcw = (cls == C_JALR);
                bus.pc_src_o = PC_JALR;
                bus.wb_sel_o = (cls == C_LOAD) ? WB_MEM : (cls == C_JALR) ? WB_PC : WB_ALUOUT;
                nxt = S_FETCH;
            end
            S_ERROR: nxt = S_ERROR;
            default: nxt = S_FETCH;
        endcase
    end

    // state, sticky error code, memory wait counter and retire counter
    always_ff @(posedge clk) begin
        if (reset) begin
            st <= S_FETCH;
            err_code <= ERR_NONE;
            wait_cnt <= '0;
            instret <= '0;
        end else begin
            st <= nxt;
            err_code <= err_nxt;
            wait_cnt <= (in_req && !bus.mem_ready_i && !timeout) ? wait_cnt + CW'(1) : '0;
            instret <= instret + INSTRET_W'(done);
        end
    end

    assign bus.mem_req_o    = req && !reset;
    assign bus.mem_we_o     = we && !reset;
    assign bus.ir_write_o   = irw && !reset;
    assign bus.pc_write_o   = pcw && !reset;
    assign bus.reg_write_o  = rw && !reset;
    assign bus.instr_done_o = done && !reset;
    assign bus.instret_o    = instret;
    assign bus.err_o        = (err_code != ERR_NONE);
    assign bus.err_code_o   = err_code;
endmodule
